box_operand_loader: RTL and testbench
=====================================

BOX_OPERAND_LOADER -- requirements
Module: box_operand_loader

Interface
REQ-001 The module SHALL have the port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The module SHALL have the port `rst`, input, 1 bit: reset, synchronous and active-high.
REQ-003 The module SHALL have the port `in_valid`, input, 1 bit: an upstream nibble is present on `in_data`.
REQ-004 The module SHALL have the port `in_data`, input, 4 bits: coordinate nibble, sent in the order A, B, C, D.
REQ-005 The module SHALL have the port `in_ready`, output, 1 bit: the loader accepts a nibble this cycle.
REQ-006 The module SHALL have the port `abort`, input, 1 bit: discards a partially collected operand set.
REQ-007 The module SHALL have the ports `op_a`, `op_b`, `op_c`, `op_d`, output, 4 bits each: registered operands driving the box-area stage (corner 1 = A,B; corner 2 = C,D).
REQ-008 The module SHALL have the port `op_valid`, output, 1 bit: the operand set is complete and held stable.
REQ-009 The module SHALL have the port `op_ready`, input, 1 bit: the downstream stage consumes the set this cycle.
REQ-010 The module SHALL have the port `slot`, output, 2 bits: index of the next nibble expected (0=A, 1=B, 2=C, 3=D).
REQ-011 The module SHALL have the port `ops_done`, output, 8 bits: count of completed handshakes, wrapping modulo 256.

Function
REQ-012 The module SHALL implement a two-state FSM with states COLLECT and HOLD.
REQ-013 The module SHALL define the input transfer as `in_valid & in_ready` on a rising edge.
REQ-014 In COLLECT, `in_ready` SHALL be 1, and in HOLD `in_ready` SHALL be 0.
REQ-015 On a transfer in COLLECT, the module SHALL write `in_data` into the operand register selected by `slot` and then increment `slot`.
REQ-016 When the transfer occurs at `slot`=3, the module SHALL set `slot` to 0, move to HOLD, and assert `op_valid` on the following cycle, giving 1 cycle latency from the D nibble to `op_valid`.
REQ-017 `op_valid` SHALL be 1 exactly in HOLD, and `op_a` through `op_d` SHALL not change while `op_valid` is 1.
REQ-018 In HOLD with `op_ready`=1, the module SHALL return to COLLECT on the next cycle and increment `ops_done`.
REQ-019 In HOLD with `op_ready`=0, the module SHALL stay in HOLD indefinitely and apply back-pressure to upstream through `in_ready`=0.
REQ-020 `op_ready` SHALL be ignored in COLLECT.
REQ-021 `abort`=1 in COLLECT SHALL set `slot` to 0, and a simultaneous input transfer in that cycle SHALL be discarded.
REQ-022 `abort` SHALL have no effect in HOLD, so a complete set is never dropped.
REQ-023 Operand registers not yet rewritten in the current set SHALL keep their previous values; only the outputs qualified by `op_valid` are meaningful.
REQ-024 `ops_done` SHALL wrap from 255 to 0 with no flag.
REQ-025 The module SHALL contain no combinational path from `in_valid` or `in_data` to any output.
REQ-026 `in_ready` and `op_valid` SHALL be decoded from state only.

Reset
REQ-027 On `rst`=1 at a rising edge, the module SHALL set state to COLLECT, `slot`=0, `ops_done`=0, and `op_a`, `op_b`, `op_c`, `op_d`=0.
REQ-028 After reset, the outputs SHALL be `op_valid`=0 and `in_ready`=1.
REQ-029 Reset SHALL take priority over `abort`, transfers and handshakes in the same cycle.
REQ-030 Reset asserted mid-collection or in HOLD SHALL discard the pending set without incrementing `ops_done`.

Structure
REQ-031 The FSM state encoding, the slot indices (SLOT_A through SLOT_D) and the 4-bit coordinate width constant SHALL live in the shared SPU package.
REQ-032 The module SHALL contain no sub-module.
REQ-033 The module SHALL be instantiated beside the box-area operator, with `op_*` wired directly to its A, B, C and D inputs.

Verification
REQ-034 Send nibbles 2, 3, 7, 9 back-to-back with `op_ready`=1 -> `op_valid` is 1 one cycle after the D transfer with A=2, B=3, C=7, D=9; the box-area outputs show M=12 and N=14; `ops_done`=1.
REQ-035 Hold `op_ready`=0 for 5 cycles in HOLD while `in_valid`=1 -> `in_ready`=0 and the operands stay stable throughout; raising `op_ready` returns the FSM to COLLECT on the next cycle.
REQ-036 Send A=1 and B=1, then pulse `abort` together with a valid nibble 5 -> `slot`=0; then send 4, 4, 6, 8 -> the operands are 4, 4, 6, 8.
REQ-037 Assert `rst` in HOLD and again at `slot`=2 -> all outputs return to their reset values, `ops_done` is unchanged at 0, and `in_ready`=1.
REQ-038 Complete 256 operand sets -> `ops_done` wraps to 0, and the 257th set gives `ops_done`=1.
REQ-039 Drive random `in_valid`/`op_ready` stalls over 1000 sets -> every delivered set matches the scoreboard order, and no nibble is lost or duplicated.

Source files
------------

// File: rtl/box_operand_loader_pkg.sv
// Shared constants and types for the box operand loader: FSM encoding,
// nibble slot indices and coordinate width.
package box_operand_loader_pkg;

   localparam int unsigned COORD_W = 4;

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SLOT_A = 2'd0,
      SLOT_B = 2'd1,
      SLOT_C = 2'd2,
      SLOT_D = 2'd3
   } slot_t;

endpackage

// File: rtl/box_operand_loader.sv
// Collects four coordinate nibbles (A, B, C, D) into registered operands and
// holds the complete set until the box-area stage accepts it.
module box_operand_loader
   import box_operand_loader_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [COORD_W-1:0] in_data,
   output logic               in_ready,
   input  logic               abort,
   output logic [COORD_W-1:0] op_a,
   output logic [COORD_W-1:0] op_b,
   output logic [COORD_W-1:0] op_c,
   output logic [COORD_W-1:0] op_d,
   output logic               op_valid,
   input  logic               op_ready,
   output logic [1:0]         slot,
   output logic [7:0]         ops_done
);

   state_t state;
   slot_t  slot_q;

   // Handshake outputs depend on the state register only.
   assign in_ready = (state == COLLECT);
   assign op_valid = (state == HOLD);
   assign slot     = slot_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= COLLECT;
         slot_q   <= SLOT_A;
         ops_done <= '0;
         op_a     <= '0;
         op_b     <= '0;
         op_c     <= '0;
         op_d     <= '0;
      end else begin
         case (state)
            COLLECT: begin
               if (abort) begin
                  // Abort wins over a coincident transfer: the nibble is dropped.
                  slot_q <= SLOT_A;
               end else if (in_valid) begin
                  case (slot_q)
                     SLOT_A: op_a <= in_data;
                     SLOT_B: op_b <= in_data;
                     SLOT_C: op_c <= in_data;
                     SLOT_D: op_d <= in_data;
                     default: ;
                  endcase
                  if (slot_q == SLOT_D) begin
                     slot_q <= SLOT_A;
                     state  <= HOLD;
                  end else begin
                     slot_q <= slot_t'(slot_q + 2'd1);
                  end
               end
            end
            HOLD: begin
               if (op_ready) begin
                  state    <= COLLECT;
                  ops_done <= ops_done + 8'd1;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_box_operand_loader.sv
// Directed and randomized-stall checks for box_operand_loader.
module tb_box_operand_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       abort;
   logic [3:0] op_a, op_b, op_c, op_d;
   logic       op_valid;
   logic       op_ready;
   logic [1:0] slot;
   logic [7:0] ops_done;

   int passed = 0;
   int total  = 0;

   box_operand_loader dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .abort    (abort),
      .op_a     (op_a),
      .op_b     (op_b),
      .op_c     (op_c),
      .op_d     (op_d),
      .op_valid (op_valid),
      .op_ready (op_ready),
      .slot     (slot),
      .ops_done (ops_done)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_data = '0; abort = 1'b0; op_ready = 1'b0;
      step(); step();
      rst = 1'b0;
      total++;
      if ({op_valid, in_ready, slot, ops_done, op_a, op_b, op_c, op_d} !== {1'b0, 1'b1, 2'd0, 8'd0, 16'h0000})
         $display("FAIL reset: got v=%b r=%b slot=%0d done=%0d ops=%h%h%h%h, want v=0 r=1 slot=0 done=0 ops=0000",
                  op_valid, in_ready, slot, ops_done, op_a, op_b, op_c, op_d);
      else passed++;
   endtask

   task automatic test_basic();
      op_ready = 1'b1;
      send(4'd2);
      total++;
      if (slot !== 2'd1) $display("FAIL slot_after_a: got %0d want 1", slot); else passed++;
      send(4'd3); send(4'd7);
      total++;
      if (op_valid !== 1'b0 || slot !== 2'd3) $display("FAIL pre_d: got v=%b slot=%0d want v=0 slot=3", op_valid, slot);
      else passed++;
      send(4'd9);
      total++;
      if ({op_valid, in_ready, slot, op_a, op_b, op_c, op_d} !== {1'b1, 1'b0, 2'd0, 16'h2379})
         $display("FAIL basic_set: got v=%b r=%b slot=%0d ops=%h%h%h%h want v=1 r=0 slot=0 ops=2379",
                  op_valid, in_ready, slot, op_a, op_b, op_c, op_d);
      else passed++;
      step();
      total++;
      if (op_valid !== 1'b0 || in_ready !== 1'b1 || ops_done !== 8'd1)
         $display("FAIL basic_handshake: got v=%b r=%b done=%0d want v=0 r=1 done=1", op_valid, in_ready, ops_done);
      else passed++;
   endtask

   task automatic test_backpressure();
      logic ok;
      op_ready = 1'b0;
      send(4'hA); send(4'hB); send(4'hC); send(4'hD);
      in_valid = 1'b1; in_data = 4'hF;
      ok = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (in_ready !== 1'b0 || op_valid !== 1'b1 || {op_a, op_b, op_c, op_d} !== 16'hABCD) ok = 1'b0;
         step();
      end
      total++;
      if (!ok || {in_ready, op_valid, op_a, op_b, op_c, op_d} !== {2'b01, 16'hABCD})
         $display("FAIL backpressure: got r=%b v=%b ops=%h%h%h%h want r=0 v=1 ops=ABCD stable",
                  in_ready, op_valid, op_a, op_b, op_c, op_d);
      else passed++;
      op_ready = 1'b1;
      step();
      in_valid = 1'b0;
      total++;
      if (op_valid !== 1'b0 || in_ready !== 1'b1 || ops_done !== 8'd2 || slot !== 2'd0)
         $display("FAIL release: got v=%b r=%b done=%0d slot=%0d want v=0 r=1 done=2 slot=0",
                  op_valid, in_ready, ops_done, slot);
      else passed++;
   endtask

   task automatic test_abort();
      send(4'd1); send(4'd1);
      abort = 1'b1; in_valid = 1'b1; in_data = 4'd5;
      step();
      abort = 1'b0; in_valid = 1'b0;
      total++;
      // op_c still carries C from the previous set; the aborted nibble 5 must not land.
      if (slot !== 2'd0 || op_c !== 4'hC || op_a !== 4'd1)
         $display("FAIL abort: got slot=%0d a=%0d c=%h want slot=0 a=1 c=C", slot, op_a, op_c);
      else passed++;
      // abort in HOLD is ignored
      op_ready = 1'b0;
      send(4'd4); send(4'd4); send(4'd6); send(4'd8);
      abort = 1'b1; step(); abort = 1'b0;
      total++;
      if (op_valid !== 1'b1 || {op_a, op_b, op_c, op_d} !== 16'h4468)
         $display("FAIL abort_set: got v=%b ops=%h%h%h%h want v=1 ops=4468", op_valid, op_a, op_b, op_c, op_d);
      else passed++;
      op_ready = 1'b1; step();
      total++;
      if (ops_done !== 8'd3) $display("FAIL abort_done: got %0d want 3", ops_done); else passed++;
   endtask

   task automatic test_reset_mid();
      op_ready = 1'b0;
      send(4'd1); send(4'd2); send(4'd3); send(4'd4);
      op_ready = 1'b1; abort = 1'b1;
      do_reset();
      abort = 1'b0;
      total++;
      if ({op_valid, in_ready, slot, ops_done, op_a, op_b, op_c, op_d} !== {1'b0, 1'b1, 2'd0, 8'd0, 16'h0000})
         $display("FAIL reset_hold: got v=%b r=%b slot=%0d done=%0d ops=%h%h%h%h want 0 1 0 0 0000",
                  op_valid, in_ready, slot, ops_done, op_a, op_b, op_c, op_d);
      else passed++;
      send(4'd5); send(4'd6);
      in_valid = 1'b1; in_data = 4'd7;
      do_reset();
      in_valid = 1'b0;
      total++;
      if ({op_valid, in_ready, slot, ops_done, op_a, op_b, op_c, op_d} !== {1'b0, 1'b1, 2'd0, 8'd0, 16'h0000})
         $display("FAIL reset_slot2: got v=%b r=%b slot=%0d done=%0d ops=%h%h%h%h want 0 1 0 0 0000",
                  op_valid, in_ready, slot, ops_done, op_a, op_b, op_c, op_d);
      else passed++;
   endtask

   task automatic test_wrap();
      op_ready = 1'b1;
      for (int unsigned n = 0; n < 256; n++) begin
         send(4'(n)); send(4'(n + 1)); send(4'(n + 2)); send(4'(n + 3));
         step();
      end
      total++;
      if (ops_done !== 8'd0) $display("FAIL wrap_256: got %0d want 0", ops_done); else passed++;
      send(4'd1); send(4'd2); send(4'd3); send(4'd4);
      step();
      total++;
      if (ops_done !== 8'd1) $display("FAIL wrap_257: got %0d want 1", ops_done); else passed++;
   endtask

   task automatic test_random_stalls();
      logic [15:0] sb[$];
      logic [15:0] part;
      logic [15:0] exp_set;
      logic        m_hold;
      int          m_slot;
      int          delivered;
      int          flow_errs;
      int          cycles;
      do_reset();
      m_hold = 1'b0; m_slot = 0; delivered = 0; flow_errs = 0; cycles = 0; part = '0;
      while (delivered < 1000 && cycles < 40000) begin
         in_valid = ($urandom_range(0, 9) < 7);
         in_data  = 4'($urandom);
         op_ready = ($urandom_range(0, 9) < 6);
         #1;
         if (in_ready !== !m_hold || op_valid !== m_hold) flow_errs++;
         if (!m_hold) begin
            if (in_valid) begin
               part[15 - 4*m_slot -: 4] = in_data;
               if (m_slot == 3) begin
                  sb.push_back(part);
                  m_hold = 1'b1;
                  m_slot = 0;
               end else m_slot++;
            end
         end else if (op_ready) begin
            exp_set = sb.pop_front();
            total++;
            if ({op_a, op_b, op_c, op_d} !== exp_set)
               $display("FAIL random_set %0d: got %h%h%h%h want %h", delivered, op_a, op_b, op_c, op_d, exp_set);
            else passed++;
            delivered++;
            m_hold = 1'b0;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      in_valid = 1'b0;
      total++;
      if (delivered != 1000 || flow_errs != 0)
         $display("FAIL random_flow: got delivered=%0d flow_errs=%0d want 1000 and 0", delivered, flow_errs);
      else passed++;
      total++;
      if (ops_done !== 8'(1000 % 256)) $display("FAIL random_done: got %0d want %0d", ops_done, 1000 % 256);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_wrap();
      test_random_stalls();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
